// File: rtl/lcd_pkg.sv
// Shared state encoding, LCD command constants and helpers for the LCD write-bus logic.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_EXEC   = 3'd4
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Clear and return-home (0x02, and 0x03 which the controller also decodes as home)
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] db);
    return !rs && ((db == LCD_CMD_CLEAR) || (db[7:1] == LCD_CMD_HOME[7:1]));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter; done flags the last cycle of a loaded interval (count of 1).
module lcd_cycle_timer #(
  parameter int W = 8
) (
  input  logic         mclk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst)              cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - W'(1);
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter for an HD44780-style 8-bit write bus; sequences one
// byte per grant (setup, E strobe, hold, execution wait) and acks the requester.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | bus parked on last RS/DB, waiting for a request
//   S_SETUP  | RS/DB driven for the granted byte, E low
//   S_STROBE | E high
//   S_HOLD   | E low again, RS/DB held
//   S_EXEC   | controller execution wait; ack on the last cycle
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC     = 2,
  parameter int E_HIGH_CYC    = 5,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 10000,
  parameter int LONG_EXEC_CYC = 400000
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] db0,
  input  logic [7:0] db1,
  output logic [1:0] ack,
  output logic       busy,
  output logic       E,
  output logic       RS,
  output logic       RW,
  output logic [7:0] DB
);

  localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, E_HIGH_CYC),
                                           max_int(HOLD_CYC, EXEC_CYC)), LONG_EXEC_CYC);
  localparam int TW = $clog2(MAX_CYC) + 1;

  lcd_state_e    state, state_nxt;
  logic          grant;
  logic          pick;
  logic          t_load;
  logic [TW-1:0] t_val;
  logic          t_done;

  // grant holds the last winner, so on a tie the other requester goes next
  assign pick = (req == 2'b11) ? ~grant : req[1];

  lcd_cycle_timer #(.W(TW)) u_timer (
    .mclk     (mclk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    t_load    = 1'b0;
    t_val     = '0;
    case (state)
      S_IDLE: if (|req) begin
        state_nxt = S_SETUP;
        t_load    = 1'b1;
        t_val     = TW'(SETUP_CYC);
      end
      S_SETUP: if (t_done) begin
        state_nxt = S_STROBE;
        t_load    = 1'b1;
        t_val     = TW'(E_HIGH_CYC);
      end
      S_STROBE: if (t_done) begin
        state_nxt = S_HOLD;
        t_load    = 1'b1;
        t_val     = TW'(HOLD_CYC);
      end
      S_HOLD: if (t_done) begin
        state_nxt = S_EXEC;
        t_load    = 1'b1;
        t_val     = is_long_cmd(RS, DB) ? TW'(LONG_EXEC_CYC) : TW'(EXEC_CYC);
      end
      S_EXEC: if (t_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Byte is captured at grant; later changes on the request side are ignored
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      grant <= 1'b1;
      RS    <= 1'b0;
      DB    <= 8'h00;
    end else if (state == S_IDLE && |req) begin
      grant <= pick;
      RS    <= pick ? rs1 : rs0;
      DB    <= pick ? db1 : db0;
    end
  end

  assign E    = (state == S_STROBE);
  assign busy = (state != S_IDLE);
  assign ack  = (state == S_EXEC && t_done) ? {grant, ~grant} : 2'b00;
  assign RW   = 1'b0;

endmodule
